// File: rtl/fft_mem_ctrl_if.sv
// fft_mem_ctrl_if: control/address bundle between the FFT sequencer and its RAM/ROM datapath.
interface fft_mem_ctrl_if #(parameter int M = 9);
    logic         start;
    logic         busy;
    logic         done;
    logic [3:0]   stage;
    logic [M-1:0] ram0_adr_a;
    logic [M-1:0] ram0_adr_b;
    logic [M-1:0] ram1_adr_a;
    logic [M-1:0] ram1_adr_b;
    logic         ram0_we;
    logic         ram1_we;
    logic         rd_bank;
    logic [M-2:0] twiddle_adr;
    logic         result_bank;
    modport master (
        input  start,
        output busy, done, stage, ram0_adr_a, ram0_adr_b, ram1_adr_a, ram1_adr_b,
               ram0_we, ram1_we, rd_bank, twiddle_adr, result_bank
    );
    modport slave (
        output start,
        input  busy, done, stage, ram0_adr_a, ram0_adr_b, ram1_adr_a, ram1_adr_b,
               ram0_we, ram1_we, rd_bank, twiddle_adr, result_bank
    );
endinterface

// File: rtl/fft_mem_ctrl.sv
// fft_mem_ctrl: radix-2 FFT stage/butterfly sequencer with ping-pong RAM addressing
// and a write-back pipeline matched to the butterfly latency.
module fft_mem_ctrl #(
    parameter int N        = 512,
    parameter int M        = $clog2(N),
    parameter int BFLY_LAT = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    fft_mem_ctrl_if.master  bus
);
    localparam int HALF = N / 2;
    localparam int DW   = $clog2(BFLY_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic         v;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic         bk;
    } wr_t;

    state_t       state_q, state_d;
    logic [3:0]   s_q, s_d;
    logic [M-2:0] i_q, i_d;
    logic [DW-1:0] d_q, d_d;
    logic [M-1:0] rda_q, rda_d, rdb_q, rdb_d;
    logic [M-2:0] tw_q, tw_d;
    logic [M-1:0] ext, span, pos, adr;
    wr_t          pipe_q [BFLY_LAT];
    wr_t          wr;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        i_d     = i_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                s_d     = '0;
                i_d     = '0;
            end
            RUN: begin
                i_d = i_q + 1'b1;
                if (i_q == (M-1)'(HALF - 1)) begin
                    state_d = DRAIN;
                    i_d     = '0;
                    d_d     = '0;
                end
            end
            DRAIN: begin
                d_d = d_q + 1'b1;
                if (d_q == DW'(BFLY_LAT - 1)) begin
                    state_d = (s_q < 4'(M - 1)) ? RUN : DONE;
                    s_d     = (s_q < 4'(M - 1)) ? s_q + 4'd1 : s_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read addresses are computed from the next state so they are registered outputs.
    always_comb begin
        ext   = {1'b0, i_d};
        span  = M'(1) << s_d;
        pos   = ext & (span - 1'b1);
        adr   = ((ext >> s_d) << (s_d + 4'd1)) | pos;
        rda_d = (state_d == RUN) ? adr : '0;
        rdb_d = (state_d == RUN) ? adr + span : '0;
        tw_d  = (state_d == RUN) ? pos[M-2:0] << (4'(M - 1) - s_d) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            i_q     <= '0;
            d_q     <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            i_q     <= i_d;
            d_q     <= d_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            tw_q    <= tw_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < BFLY_LAT; j++) pipe_q[j] <= '0;
        end else begin
            pipe_q[0] <= '{v: state_q == RUN, a: rda_q, b: rdb_q, bk: ~s_q[0]};
            for (int j = 1; j < BFLY_LAT; j++) pipe_q[j] <= pipe_q[j-1];
        end
    end

    assign wr = pipe_q[BFLY_LAT-1];

    // Write-back owns a bank's ports when due; otherwise the read side drives them (zero outside RUN).
    assign bus.ram0_adr_a  = (wr.v && !wr.bk) ? wr.a : (s_q[0] ? '0 : rda_q);
    assign bus.ram0_adr_b  = (wr.v && !wr.bk) ? wr.b : (s_q[0] ? '0 : rdb_q);
    assign bus.ram1_adr_a  = (wr.v &&  wr.bk) ? wr.a : (s_q[0] ? rda_q : '0);
    assign bus.ram1_adr_b  = (wr.v &&  wr.bk) ? wr.b : (s_q[0] ? rdb_q : '0);
    assign bus.ram0_we     = wr.v && !wr.bk;
    assign bus.ram1_we     = wr.v &&  wr.bk;
    assign bus.twiddle_adr = tw_q;
    assign bus.rd_bank     = s_q[0];
    assign bus.stage       = s_q;
    assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);
    assign bus.result_bank = 1'(M % 2);
endmodule

// File: tb/tb_fft_mem_ctrl.sv
// tb_fft_mem_ctrl: directed sequence with randomized start/reset timing, checked against
// an arithmetic model of the stage/butterfly schedule and a per-stage write scoreboard.
module tb_fft_mem_ctrl;
    localparam int N    = 512;
    localparam int M    = 9;
    localparam int L    = 2;
    localparam int HALF = N / 2;
    localparam int SPS  = HALF + L;
    localparam int TOT  = M * SPS;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    fft_mem_ctrl_if #(.M(M)) bus ();
    fft_mem_ctrl #(.N(N), .M(M), .BFLY_LAT(L)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_a(int s, int i);
        int span = 1 << s;
        return (i / span) * 2 * span + i % span;
    endfunction

    function automatic int m_tw(int s, int i);
        return (i % (1 << s)) * (1 << (M - 1 - s));
    endfunction

    task automatic run_check(input bit first, input bit hold);
        int bad = 0, nd = 0, bankbad = 0, cntbad = 0, ovl = 0;
        int cnt [M][N];
        logic [51:0] obs_v, exp_v;
        logic [8:0] e0a, e0b, e1a, e1b;
        logic [7:0] etw;
        logic ew0, ew1;
        for (int s = 0; s < M; s++) for (int a = 0; a < N; a++) cnt[s][a] = 0;
        bus.start = 1'b1;
        for (int t = 0; t <= TOT + 1; t++) begin
            int st = t / SPS, r = t % SPS, w = t - L;
            int wst = w / SPS, wb = 1 - (wst % 2);
            bit run  = (t < TOT) && (r < HALF);
            bit wrun = (w >= 0) && (w < TOT) && (w % SPS < HALF);
            @(negedge clk);
            {e0a, e0b, e1a, e1b, etw, ew0, ew1} = '0;
            if (run) begin
                if (st % 2 == 0) begin
                    e0a = 9'(m_a(st, r));
                    e0b = 9'(m_a(st, r) + (1 << st));
                end else begin
                    e1a = 9'(m_a(st, r));
                    e1b = 9'(m_a(st, r) + (1 << st));
                end
                etw = 8'(m_tw(st, r));
            end
            if (wrun) begin
                if (wb == 0) begin
                    ew0 = 1'b1;
                    e0a = 9'(m_a(wst, w % SPS));
                    e0b = 9'(m_a(wst, w % SPS) + (1 << wst));
                end else begin
                    ew1 = 1'b1;
                    e1a = 9'(m_a(wst, w % SPS));
                    e1b = 9'(m_a(wst, w % SPS) + (1 << wst));
                end
            end
            exp_v = {t < TOT, t == TOT, 4'((t < TOT) ? st : M - 1), ew0, ew1, e0a, e0b, e1a, e1b, etw};
            obs_v = {bus.busy, bus.done, bus.stage, bus.ram0_we, bus.ram1_we, bus.ram0_adr_a,
                     bus.ram0_adr_b, bus.ram1_adr_a, bus.ram1_adr_b, bus.twiddle_adr};
            if (obs_v !== exp_v) bad++;
            if (run && bus.rd_bank !== 1'(st % 2)) bad++;
            if (bus.done) nd++;
            if (run && ((bus.ram0_we && st % 2 == 0) || (bus.ram1_we && st % 2 == 1))) ovl++;
            if (bus.ram0_we || bus.ram1_we) begin
                if (w < 0 || wst >= M) cntbad++;
                else begin
                    if (bus.ram0_we) begin
                        cnt[wst][bus.ram0_adr_a]++;
                        cnt[wst][bus.ram0_adr_b]++;
                        if (wst % 2 != 1) bankbad++;
                    end
                    if (bus.ram1_we) begin
                        cnt[wst][bus.ram1_adr_a]++;
                        cnt[wst][bus.ram1_adr_b]++;
                        if (wst % 2 != 0) bankbad++;
                    end
                end
            end
            if (first) begin
                if (t == 0) begin
                    chk("s0_i0_adr_a", bus.ram0_adr_a, 0);
                    chk("s0_i0_adr_b", bus.ram0_adr_b, 1);
                    chk("s0_i0_tw", bus.twiddle_adr, 0);
                    chk("s0_rd_bank", bus.rd_bank, 0);
                end
                if (t == 1) begin
                    chk("s0_i1_adr_a", bus.ram0_adr_a, 2);
                    chk("s0_i1_adr_b", bus.ram0_adr_b, 3);
                end
                if (t == 2) begin
                    chk("s0_wr_we1", bus.ram1_we, 1);
                    chk("s0_wr_adr", {bus.ram1_adr_a, bus.ram1_adr_b}, {9'd0, 9'd1});
                end
                if (t == SPS + 1) begin
                    chk("s1_i1_adr", {bus.ram1_adr_a, bus.ram1_adr_b}, {9'd1, 9'd3});
                    chk("s1_i1_tw", bus.twiddle_adr, 128);
                    chk("s1_rd_bank", bus.rd_bank, 1);
                end
                if (t == 8 * SPS) begin
                    chk("s8_i0_adr", {bus.ram0_adr_a, bus.ram0_adr_b}, {9'd0, 9'd256});
                    chk("s8_i0_tw", bus.twiddle_adr, 0);
                end
                if (t == 8 * SPS + 1) begin
                    chk("s8_i1_adr", {bus.ram0_adr_a, bus.ram0_adr_b}, {9'd1, 9'd257});
                    chk("s8_i1_tw", bus.twiddle_adr, 1);
                end
            end
            if (t == TOT) chk("done_at_2322", {bus.done, bus.busy}, 2'b10);
            if (t == TOT + 1) chk("idle_after_done", {bus.done, bus.busy}, 2'b00);
            bus.start = hold ? 1'b1 : (t < TOT ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        for (int s = 0; s < M; s++) for (int a = 0; a < N; a++) if (cnt[s][a] != 1) cntbad++;
        chk("cycle_model_errs", bad, 0);
        chk("done_pulses", nd, 1);
        chk("write_bank_errs", bankbad, 0);
        chk("write_once_errs", cntbad, 0);
        chk("rw_overlap", ovl, 0);
        chk("result_bank", bus.result_bank, 1);
    endtask

    task automatic reset_mid();
        int rb = 0;
        int rt = $urandom_range(5, TOT - 20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (rt) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ctrl", {bus.busy, bus.done, bus.ram0_we, bus.ram1_we, bus.rd_bank, bus.stage}, 0);
        chk("rst_adr0", {bus.ram0_adr_a, bus.ram0_adr_b}, 0);
        chk("rst_adr1", {bus.ram1_adr_a, bus.ram1_adr_b}, 0);
        chk("rst_tw", bus.twiddle_adr, 0);
        chk("rst_result_bank", bus.result_bank, 1);
        repeat (3) begin
            @(posedge clk);
            #1 if (bus.ram0_we || bus.ram1_we || bus.busy) rb++;
        end
        chk("rst_hold_quiet", rb, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {bus.busy, bus.done, bus.stage}, 0);
    endtask

    initial begin
        int q = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {bus.busy, bus.done, bus.ram0_we, bus.ram1_we, bus.stage}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        run_check(1'b1, 1'b0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        reset_mid();
        run_check(1'b0, 1'b1);
        run_check(1'b0, 1'b1);
        bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.done) q++;
        end
        chk("idle_no_queue", q, 0);
        run_check(1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
